serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 90 +++++++++
 tb/tb_serial_subtractor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor:
// FSM state encoding and the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell used by the serial datapath.
// Purely combinational: diff = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic axb;

    assign axb  = a ^ b;
    assign diff = axb ^ bin;
    assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b mod 2^WIDTH, LSB first,
// one bit per clock through a single full-subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             br;
    logic             d_bit;
    logic             br_n;
    logic             last;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .diff (d_bit),
        .bout (br_n)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Result bits enter at the MSB so that after WIDTH shifts
    // the LSB-first stream lands in natural bit order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                a_sr <= a;
                b_sr <= b;
                br   <= 1'b0;
                cnt  <= '0;
            end
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {d_bit, res_sr[WIDTH-1:1]};
            br     <= br_n;
            cnt    <= cnt + CW'(1);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign diff = res_sr;
    assign bout = br;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4),
// compared against plain-arithmetic subtraction.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bout8;

    logic       rst4;
    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       bout4;

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst8),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst4),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one WIDTH=8 operation; operands are scrambled during RUN,
    // and when inj >= 0 a stray start with new operands is pulsed.
    task automatic do_op8(input logic [7:0] x,
                          input logic [7:0] y,
                          input int inj,
                          input string tag);
        int         k;
        int         busy_n;
        int         done_n;
        int         lat;
        logic [7:0] d;
        logic       bo;
        logic [7:0] exp_d;
        a8     = x;
        b8     = y;
        start8 = 1'b1;
        step();
        k      = 0;
        busy_n = 0;
        done_n = 0;
        lat    = -1;
        d      = '0;
        bo     = 1'b0;
        while (busy8 && k < 40) begin
            busy_n++;
            if (done8) begin
                done_n++;
                lat = k;
                d   = diff8;
                bo  = bout8;
            end
            if (k == inj) begin
                start8 = 1'b1;
                a8     = 8'h00;
                b8     = 8'hFF;
            end else begin
                start8 = 1'b0;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
            end
            step();
            k++;
        end
        start8 = 1'b0;
        exp_d  = x - y;
        check({tag, ".diff"}, 32'(d), 32'(exp_d));
        check({tag, ".bout"}, 32'(bo), 32'(x < y));
        check({tag, ".latency"}, 32'(lat), 32'd8);
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'd9);
        check({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        check({tag, ".held_diff"}, 32'(diff8), 32'(exp_d));
        check({tag, ".held_bout"}, 32'(bout8), 32'(x < y));
        check({tag, ".idle"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] exp4;
        int         k;
        int         seen;

        rst8   = 1'b1;
        rst4   = 1'b1;
        start8 = 1'b0;
        start4 = 1'b0;
        a8     = '0;
        b8     = '0;
        a4     = '0;
        b4     = '0;
        #1;
        check("reset.busy", 32'(busy8), 32'd0);
        check("reset.done", 32'(done8), 32'd0);
        check("reset.diff", 32'(diff8), 32'd0);
        check("reset.bout", 32'(bout8), 32'd0);
        check("reset.busy4", 32'(busy4), 32'd0);
        step();
        rst8 = 1'b0;
        rst4 = 1'b0;
        step();

        do_op8(8'h35, 8'h12, -1, "op35_12");
        do_op8(8'h12, 8'h35, -1, "op12_35");
        do_op8(8'h00, 8'h01, -1, "op00_01");
        do_op8(8'hFF, 8'hFF, -1, "opFF_FF");
        do_op8(8'h80, 8'h00, -1, "op80_00");
        do_op8(8'h10, 8'h01, 2, "stray_start");
        step();
        step();
        check("stray_start.no_requeue", 32'(busy8), 32'd0);

        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op8(ra, rb, -1, "random");
        end

        a8     = 8'h5A;
        b8     = 8'h3C;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        step();
        rst8 = 1'b1;
        #1;
        check("abort.busy", 32'(busy8), 32'd0);
        check("abort.done", 32'(done8), 32'd0);
        check("abort.diff", 32'(diff8), 32'd0);
        check("abort.bout", 32'(bout8), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) seen++;
        end
        check("abort.no_done", 32'(seen), 32'd0);
        rst8 = 1'b0;
        do_op8(8'h05, 8'h07, -1, "after_reset");

        for (int i = 0; i < 256; i++) begin
            x      = 4'(i >> 4);
            y      = 4'(i);
            a4     = x;
            b4     = y;
            start4 = 1'b1;
            step();
            start4 = 1'b0;
            a4     = 4'($urandom);
            b4     = 4'($urandom);
            k      = 0;
            while (!done4 && k < 20) begin
                step();
                k++;
            end
            exp4 = x - y;
            check("sweep4.latency", 32'(k), 32'd4);
            check("sweep4.diff", 32'(diff4), 32'(exp4));
            check("sweep4.bout", 32'(bout4), 32'(x < y));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
